// File: rtl/uart_baud_ctrl_if.sv
// rtl/uart_baud_ctrl_if.sv - host/config side bundle of the baud-rate controller
interface uart_baud_ctrl_if #(
    parameter int PHASE_WIDTH = 32
);
    logic                   cfg_wr;
    logic [PHASE_WIDTH-1:0] cfg_inc;
    logic                   ab_start;
    logic                   ab_abort;
    logic                   ab_busy;
    logic                   ab_done;
    logic                   ab_err;
    logic [PHASE_WIDTH-1:0] phase_increment;

    modport master (
        output cfg_wr, cfg_inc, ab_start, ab_abort,
        input  ab_busy, ab_done, ab_err, phase_increment
    );

    modport slave (
        input  cfg_wr, cfg_inc, ab_start, ab_abort,
        output ab_busy, ab_done, ab_err, phase_increment
    );
endinterface

// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - DDS phase-increment register with 0x55 auto-baud measurement
module uart_baud_ctrl #(
    parameter int                     PHASE_WIDTH = 32,
    parameter int                     OVERSAMPLE  = 16,
    parameter int                     CNT_WIDTH   = 24,
    parameter logic [PHASE_WIDTH-1:0] RESET_INC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    uart_baud_ctrl_if.slave   bus
);
    // Dividend is OVERSAMPLE * 2^(PHASE_WIDTH+3) = 2^Q_W, a single one above the
    // quotient width, so the divider starts with remainder 1 and shifts in zeros.
    localparam int Q_W    = PHASE_WIDTH + 3 + $clog2(OVERSAMPLE);
    localparam int DIV_CW = $clog2(Q_W);
    localparam logic [DIV_CW-1:0]    DIV_LAST = DIV_CW'(Q_W - 1);
    localparam logic [CNT_WIDTH:0]   MIN_M    = (CNT_WIDTH + 1)'(16 * OVERSAMPLE);
    // One below all-ones: stepping from here means cnt reaches all-ones this edge.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = {{(CNT_WIDTH - 1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_HIGH, S_WAIT_START, S_MEASURE,
        S_CHECK, S_DIVIDE, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2:0]             falls_q, falls_d;
    logic [CNT_WIDTH-1:0]   m_q, m_d;
    logic [CNT_WIDTH:0]     rem_q, rem_d;
    logic [PHASE_WIDTH-1:0] quot_q, quot_d;
    logic [DIV_CW-1:0]      div_cnt_q, div_cnt_d;
    logic [PHASE_WIDTH-1:0] inc_q, inc_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic                   fall;
    logic [CNT_WIDTH:0]     m_ext, rem_shift, rem_next;
    logic                   rem_ge;

    assign fall      = sync3_q & ~sync2_q;
    assign m_ext     = {1'b0, m_q};
    assign rem_shift = rem_q << 1;
    assign rem_ge    = (rem_shift >= m_ext);
    assign rem_next  = rem_ge ? (rem_shift - m_ext) : rem_shift;

    assign bus.phase_increment = inc_q;
    assign bus.ab_busy         = busy_q;
    assign bus.ab_done         = done_q;
    assign bus.ab_err          = err_q;

    // Next-state logic: synchronizer, measurement FSM and restoring divider.
    always_comb begin
        state_d   = state_q;
        sync1_d   = rx_i;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        cnt_d     = cnt_q;
        falls_d   = falls_q;
        m_d       = m_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        div_cnt_d = div_cnt_q;
        inc_d     = inc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_wr) begin
                    inc_d = bus.cfg_inc;
                end else if (bus.ab_start) begin
                    state_d = S_WAIT_HIGH;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (sync2_q) state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (fall) begin
                    cnt_d   = '0;
                    falls_d = 3'd1;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (fall && falls_q == 3'd4) begin
                    m_d     = cnt_q + CNT_WIDTH'(1);
                    state_d = S_CHECK;
                end else begin
                    if (fall) falls_d = falls_q + 3'd1;
                    if (cnt_q == CNT_LAST) state_d = S_ERR;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_CHECK: begin
                // Too short a bit period would overflow the quotient or push the DDS past clk/2.
                if (m_ext < MIN_M) begin
                    state_d = S_ERR;
                end else begin
                    rem_d     = (CNT_WIDTH + 1)'(1);
                    quot_d    = '0;
                    div_cnt_d = DIV_LAST;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d     = rem_next;
                quot_d    = (quot_q << 1) | PHASE_WIDTH'(rem_ge);
                div_cnt_d = div_cnt_q - DIV_CW'(1);
                if (div_cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                inc_d   = quot_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything once a measurement is in flight.
        if (state_q != S_IDLE && bus.ab_abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            inc_d   = inc_q;
        end
    end

    // State register with synchronous reset; the line synchronizer idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            cnt_q     <= '0;
            falls_q   <= '0;
            m_q       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            div_cnt_q <= '0;
            inc_q     <= RESET_INC;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            cnt_q     <= cnt_d;
            falls_q   <= falls_d;
            m_q       <= m_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            div_cnt_q <= div_cnt_d;
            inc_q     <= inc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb/tb_uart_baud_ctrl.sv - scoreboard bench for uart_baud_ctrl
module tb_uart_baud_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    always #5 clk = ~clk;

    uart_baud_ctrl_if #(.PHASE_WIDTH(32)) bus0 ();
    uart_baud_ctrl_if #(.PHASE_WIDTH(32)) bus1 ();

    uart_baud_ctrl dut0 (.clk(clk), .rst(rst), .rx_i(rx0), .bus(bus0));
    uart_baud_ctrl #(.CNT_WIDTH(10)) dut1 (.clk(clk), .rst(rst), .rx_i(rx1), .bus(bus1));

    // kind: 0 = increment changed by cfg write, 1 = ab_done, 2 = ab_err
    typedef struct {
        int          kind;
        logic [31:0] val;
        longint      cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [31:0] prev0, prev1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic take(input int id, input int kind, input logic [31:0] val, input logic busy);
        exp_t e;
        checks++;
        if (id == 0 && q0.size() != 0) e = q0.pop_front();
        else if (id == 1 && q1.size() != 0) e = q1.pop_front();
        else begin
            errors++;
            $display("FAIL dut%0d unexpected event: kind=%0d val=%h cyc=%0d", id, kind, val, cyc);
            return;
        end
        if (e.kind != kind || e.val !== val || busy !== 1'b0 || e.cyc != cyc) begin
            errors++;
            $display("FAIL dut%0d event: got kind=%0d val=%h busy=%b cyc=%0d, expected kind=%0d val=%h busy=0 cyc=%0d",
                     id, kind, val, busy, cyc, e.kind, e.val, e.cyc);
        end
    endtask

    // Monitor: every done/err pulse or increment change is matched against the queue.
    always @(negedge clk) begin
        if (rst) begin
            prev0 = bus0.phase_increment;
            prev1 = bus1.phase_increment;
        end else begin
            if (bus0.ab_done) take(0, 1, bus0.phase_increment, bus0.ab_busy);
            else if (bus0.ab_err) take(0, 2, bus0.phase_increment, bus0.ab_busy);
            else if (bus0.phase_increment !== prev0) take(0, 0, bus0.phase_increment, bus0.ab_busy);
            if (bus1.ab_done) take(1, 1, bus1.phase_increment, bus1.ab_busy);
            else if (bus1.ab_err) take(1, 2, bus1.phase_increment, bus1.ab_busy);
            else if (bus1.phase_increment !== prev1) take(1, 0, bus1.phase_increment, bus1.ab_busy);
            prev0 = bus0.phase_increment;
            prev1 = bus1.phase_increment;
        end
    end

    task automatic drain(input int id, input int lim);
        int left;
        for (int n = 0; n < lim; n++) begin
            left = (id == 0) ? q0.size() : q1.size();
            if (left == 0) break;
            @(posedge clk);
        end
        left = (id == 0) ? q0.size() : q1.size();
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL drain dut%0d: %0d events still pending, expected 0", id, left);
            if (id == 0) q0.delete(); else q1.delete();
        end
    endtask

    task automatic start_ab0();
        @(posedge clk); #1 bus0.ab_start = 1'b1;
        @(posedge clk); #1 bus0.ab_start = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // 0x55 frame: start, bits LSB first, stop; 5th fall is at the start of bit 7.
    // Capture edge is 3 edges after the fall is driven, done 41 later, range err 2 later.
    task automatic send_55(input int period, input int kind, input logic [31:0] val,
                           input int lat, input bit do_abort);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 rx0 = i[0];
            if (i == 8) begin
                if (kind >= 0) q0.push_back('{kind, val, cyc + lat});
                if (do_abort) begin
                    repeat (20) @(posedge clk);
                    #1 bus0.ab_abort = 1'b1;
                    @(posedge clk); #1 bus0.ab_abort = 1'b0;
                    repeat (period - 22) @(posedge clk);
                end else begin
                    repeat (period - 1) @(posedge clk);
                end
            end else begin
                repeat (period - 1) @(posedge clk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus0.cfg_wr = 1'b0; bus0.cfg_inc = '0; bus0.ab_start = 1'b0; bus0.ab_abort = 1'b0;
        bus1.cfg_wr = 1'b0; bus1.cfg_inc = '0; bus1.ab_start = 1'b0; bus1.ab_abort = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset inc", bus0.phase_increment, 32'h0);
        chk("reset busy", {31'b0, bus0.ab_busy}, 32'h0);
        chk("reset done", {31'b0, bus0.ab_done}, 32'h0);
        chk("reset err", {31'b0, bus0.ab_err}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Direct configuration write
        @(posedge clk); #1 bus0.cfg_wr = 1'b1; bus0.cfg_inc = 32'h1234_5678;
        q0.push_back('{0, 32'h1234_5678, cyc + 1});
        @(posedge clk); #1 bus0.cfg_wr = 1'b0;
        @(negedge clk);
        chk("cfg busy", {31'b0, bus0.ab_busy}, 32'h0);
        drain(0, 10);

        // Exact auto-baud: 64 cycles/bit, M=512
        start_ab0();
        @(negedge clk);
        chk("ab busy after start", {31'b0, bus0.ab_busy}, 32'h1);
        send_55(64, 1, 32'h4000_0000, 44, 1'b0);
        drain(0, 100);

        // Rounding: 100 cycles/bit, M=800
        start_ab0();
        send_55(100, 1, 32'h28F5_C28F, 44, 1'b0);
        drain(0, 100);

        // Range error: 16 cycles/bit, M=128
        start_ab0();
        send_55(16, 2, 32'h28F5_C28F, 5, 1'b0);
        drain(0, 100);

        // Abort in the middle of the division
        start_ab0();
        send_55(64, -1, 32'h0, 0, 1'b1);
        @(negedge clk);
        chk("abort busy", {31'b0, bus0.ab_busy}, 32'h0);
        chk("abort inc", bus0.phase_increment, 32'h28F5_C28F);

        // Timeout on the 10-bit counter instance
        @(posedge clk); #1 bus1.ab_start = 1'b1;
        @(posedge clk); #1 bus1.ab_start = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1 rx1 = 1'b0;
        q1.push_back('{2, 32'h0, cyc + 1027});
        drain(1, 1100);
        #1 rx1 = 1'b1;

        // cfg_wr and ab_start together in IDLE
        @(posedge clk); #1 bus0.cfg_wr = 1'b1; bus0.ab_start = 1'b1; bus0.cfg_inc = 32'hA5A5_0001;
        q0.push_back('{0, 32'hA5A5_0001, cyc + 1});
        @(posedge clk); #1 bus0.cfg_wr = 1'b0; bus0.ab_start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("cfg+start busy", {31'b0, bus0.ab_busy}, 32'h0);
        end
        drain(0, 10);

        // cfg_wr during MEASURE is ignored
        start_ab0();
        @(posedge clk); #1 rx0 = 1'b0;
        repeat (10) @(posedge clk); #1 rx0 = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus0.cfg_wr = 1'b1; bus0.cfg_inc = 32'hDEAD_BEEF;
        @(posedge clk); #1 bus0.cfg_wr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("measure cfg ignored", bus0.phase_increment, 32'hA5A5_0001);
        chk("measure busy", {31'b0, bus0.ab_busy}, 32'h1);

        // Reset in the middle of MEASURE
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst inc", bus0.phase_increment, 32'h0);
        chk("mid rst busy", {31'b0, bus0.ab_busy}, 32'h0);
        chk("mid rst done", {31'b0, bus0.ab_done}, 32'h0);
        chk("mid rst err", {31'b0, bus0.ab_err}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post rst busy", {31'b0, bus0.ab_busy}, 32'h0);

        drain(0, 5);
        drain(1, 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
